// File: rtl/abro_pkg.sv
// Shared definitions for the N-event ABRO controller: state codes and legal input range.
package abro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_FIRED   = 2'b10
    } state_e;

    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam int unsigned N_IN_MIN = 1;
    localparam int unsigned N_IN_MAX = 16;

endpackage

// File: rtl/abro_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module abro_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/abro_n_event_fsm.sv
// Waits for every event line to be seen once, fires o, then waits for restart r.
// Optional completion window aborts collection with a one-cycle timeout pulse.
module abro_n_event_fsm
    import abro_pkg::*;
#(
    parameter int unsigned N_IN       = 2,
    parameter int unsigned WIN_W      = 8,
    parameter int unsigned PULSE_MODE = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r,
    input  logic [N_IN-1:0]  ev,
    input  logic [WIN_W-1:0] win_limit,
    output logic             o,
    output logic             timeout,
    output logic [N_IN-1:0]  seen,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] fire_count
);

    localparam logic [N_IN-1:0] ALL = '1;

    if ((N_IN < N_IN_MIN) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
        $error("abro_n_event_fsm: N_IN out of legal range");
    end

    state_e           state_q;
    logic [N_IN-1:0]  seen_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             o_q;
    logic             timeout_q;

    logic [N_IN-1:0]  nxt_c;
    logic             fire_c;
    logic             expire_c;

    assign nxt_c    = seen_q | ev;
    assign expire_c = (win_limit != '0) && (win_cnt_q == WIN_W'(win_limit - WIN_W'(1)));

    // Same completion condition the FSM uses; r masks it since restart wins.
    assign fire_c = !r && (nxt_c == ALL) &&
                    (((state_q == ST_IDLE) && (ev != '0)) || (state_q == ST_COLLECT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            seen_q    <= '0;
            win_cnt_q <= '0;
            o_q       <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            o_q       <= 1'b0;
            timeout_q <= 1'b0;
            if (r) begin
                state_q   <= ST_IDLE;
                seen_q    <= '0;
                win_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ev != '0) begin
                            if (nxt_c == ALL) begin
                                state_q <= ST_FIRED;
                                seen_q  <= ALL;
                                o_q     <= 1'b1;
                            end else begin
                                state_q   <= ST_COLLECT;
                                seen_q    <= nxt_c;
                                win_cnt_q <= '0;
                            end
                        end
                    end
                    ST_COLLECT: begin
                        if (nxt_c == ALL) begin
                            state_q <= ST_FIRED;
                            seen_q  <= ALL;
                            o_q     <= 1'b1;
                        end else if (expire_c) begin
                            state_q   <= ST_IDLE;
                            seen_q    <= '0;
                            win_cnt_q <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            seen_q    <= nxt_c;
                            win_cnt_q <= win_cnt_q + WIN_W'(1);
                        end
                    end
                    ST_FIRED: begin
                        seen_q <= ALL;
                        o_q    <= (PULSE_MODE == 0);
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        seen_q    <= '0;
                        win_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    abro_sat_counter #(
        .W (CNT_W)
    ) u_fire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (fire_c),
        .clr_i (1'b0),
        .cnt_o (fire_count)
    );

    assign o       = o_q;
    assign timeout = timeout_q;
    assign seen    = seen_q;
    assign state   = state_q;

endmodule

// File: tb/tb_abro_n_event_fsm.sv
// Directed bench: a 3-input pulse-mode instance and a 2-input level-mode instance with a 2-bit counter.
module tb_abro_n_event_fsm;

    logic clk = 1'b0;
    logic reset;

    logic       a_r;
    logic [2:0] a_ev;
    logic [7:0] a_win;
    logic       a_o, a_to;
    logic [2:0] a_seen;
    logic [1:0] a_state;
    logic [7:0] a_fc;

    logic       b_r;
    logic [1:0] b_ev;
    logic [7:0] b_win;
    logic       b_o, b_to;
    logic [1:0] b_seen;
    logic [1:0] b_state;
    logic [1:0] b_fc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    abro_n_event_fsm #(.N_IN(3), .WIN_W(8), .PULSE_MODE(1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .r(a_r), .ev(a_ev), .win_limit(a_win),
        .o(a_o), .timeout(a_to), .seen(a_seen), .state(a_state), .fire_count(a_fc)
    );

    abro_n_event_fsm #(.N_IN(2), .WIN_W(8), .PULSE_MODE(0), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .r(b_r), .ev(b_ev), .win_limit(b_win),
        .o(b_o), .timeout(b_to), .seen(b_seen), .state(b_state), .fire_count(b_fc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        a_r = 1'b0; a_ev = '0; a_win = '0;
        b_r = 1'b0; b_ev = '0; b_win = '0;
        #12;
        check("rst a_state", 32'(a_state), 0);
        check("rst a_seen",  32'(a_seen),  0);
        check("rst a_o",     32'(a_o),     0);
        check("rst a_fc",    32'(a_fc),    0);
        check("rst b_state", 32'(b_state), 0);
        check("rst b_to",    32'(b_to),    0);
        reset = 1'b1;

        // Test 1: three events on successive edges, pulse output
        a_ev = 3'b001; tick();
        check("t1 state1", 32'(a_state), 1);
        check("t1 seen1",  32'(a_seen),  3'b001);
        check("t1 o1",     32'(a_o),     0);
        a_ev = 3'b100; tick();
        check("t1 state2", 32'(a_state), 1);
        check("t1 seen2",  32'(a_seen),  3'b101);
        a_ev = 3'b010; tick();
        check("t1 state3", 32'(a_state), 2);
        check("t1 seen3",  32'(a_seen),  3'b111);
        check("t1 o3",     32'(a_o),     1);
        check("t1 fc",     32'(a_fc),    1);
        a_ev = 3'b000; tick();
        check("t1 o4",     32'(a_o),     0);
        check("t1 state4", 32'(a_state), 2);
        a_ev = 3'b011; tick();
        check("t1 o5",     32'(a_o),     0);
        check("t1 seen5",  32'(a_seen),  3'b111);
        a_ev = 3'b000; a_r = 1'b1; tick();
        a_r = 1'b0;
        check("t1 r state", 32'(a_state), 0);
        check("t1 r seen",  32'(a_seen),  0);
        check("t1 r fc",    32'(a_fc),    1);

        // Test 2: both events in one cycle, level output held until r
        b_ev = 2'b11; tick();
        check("t2 state", 32'(b_state), 2);
        check("t2 o",     32'(b_o),     1);
        check("t2 fc",    32'(b_fc),    1);
        for (int i = 0; i < 5; i++) begin
            b_ev = 2'(i);
            tick();
            check("t2 o hold", 32'(b_o),     1);
            check("t2 st hold", 32'(b_state), 2);
        end
        b_ev = 2'b00; b_r = 1'b1; tick();
        b_r = 1'b0;
        check("t2 r o",     32'(b_o),     0);
        check("t2 r state", 32'(b_state), 0);
        check("t2 r fc",    32'(b_fc),    1);

        // Test 3: window of 3 expires
        b_win = 8'd3;
        b_ev = 2'b01; tick();
        check("t3 enter", 32'(b_state), 1);
        b_ev = 2'b00; tick();
        check("t3 to1", 32'(b_to), 0);
        tick();
        check("t3 to2", 32'(b_to), 0);
        check("t3 st2", 32'(b_state), 1);
        tick();
        check("t3 to3",   32'(b_to),    1);
        check("t3 state", 32'(b_state), 0);
        check("t3 seen",  32'(b_seen),  0);
        check("t3 o",     32'(b_o),     0);
        tick();
        check("t3 to4", 32'(b_to), 0);

        // Test 4: completion on the expiry edge wins
        b_ev = 2'b01; tick();
        b_ev = 2'b00; tick();
        tick();
        b_ev = 2'b10; tick();
        check("t4 o",     32'(b_o),     1);
        check("t4 to",    32'(b_to),    0);
        check("t4 state", 32'(b_state), 2);
        check("t4 fc",    32'(b_fc),    2);
        b_ev = 2'b00; b_r = 1'b1; tick();
        b_r = 1'b0;
        b_win = 8'd0;

        // Test 5: r discards same-cycle events; async reset mid-collect
        b_r = 1'b1; b_ev = 2'b11; tick();
        check("t5 r state", 32'(b_state), 0);
        check("t5 r o",     32'(b_o),     0);
        check("t5 r fc",    32'(b_fc),    2);
        b_r = 1'b0;
        b_ev = 2'b01; tick();
        check("t5 collect", 32'(b_state), 1);
        b_ev = 2'b00;
        #2 reset = 1'b0;
        #1;
        check("t5 ar state", 32'(b_state), 0);
        check("t5 ar seen",  32'(b_seen),  0);
        check("t5 ar o",     32'(b_o),     0);
        check("t5 ar to",    32'(b_to),    0);
        check("t5 ar fc",    32'(b_fc),    0);
        #1 reset = 1'b1;

        // Test 6: 2-bit fire counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            b_ev = 2'b11; tick();
            check("t6 fc", 32'(b_fc), (k < 3) ? k + 1 : 3);
            b_ev = 2'b00; b_r = 1'b1; tick();
            b_r = 1'b0;
        end
        check("t6 fc after r", 32'(b_fc), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/abro_n_event_fsm.md
Name: abro_n_event_fsm

Overview:
Parametrised successor of the team's two-input ABRO controller. It waits for each of N_IN event lines to have been seen at least once, in any order and in any combination of cycles. It then fires output o and waits for a synchronous restart r before collecting again. New relative to the two-input block:
- generic input count;
- pulse or level output mode;
- optional completion window with timeout;
- saturating fire counter.

It sits between input-conditioning logic and the system sequencer.

Parameters:
N_IN, 2, number of awaited event inputs (legal 1..16)
WIN_W, 8, width of completion-window limit and internal window counter
PULSE_MODE, 1, 1: o high for exactly one cycle per fire; 0: o held high for the whole FIRED state
CNT_W, 8, width of saturating fire counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
r  in  1  synchronous restart (the "R" of ABRO); highest priority
ev  in  N_IN  event inputs, sampled each rising edge; any bit high = that event seen
win_limit  in  WIN_W  completion window in cycles; 0 = window disabled
o  out  1  fire output (registered)
timeout  out  1  one-cycle pulse when the window expires before completion
seen  out  N_IN  accumulated seen-mask
state  out  2  current FSM state
fire_count  out  CNT_W  number of fires since reset, saturating at all-ones

Behaviour:
Interface:
- Reset is asynchronous, active-low; the clock is clk.
- While reset=0: state=IDLE, seen=0, o=0, timeout=0, fire_count=0, window counter=0.

State encoding (shared package): IDLE=2'b00, COLLECT=2'b01, FIRED=2'b10. Code 2'b11 is illegal and returns to IDLE on the next edge with seen cleared.

Definitions: ALL = N_IN ones; nxt = seen | ev; o and timeout are registered and default to 0 every cycle unless set below.

Priority at each edge: r > completion > timeout > accumulate.

Restart:
- r=1 in any state: next state=IDLE, seen=0, window counter=0, o=0, timeout=0.
- ev in the same cycle as r is discarded.
- fire_count is not cleared by r.

IDLE:
- ev==0: stay.
- nxt==ALL (e.g. all events in one cycle): go to FIRED, o=1, fire_count++.
- otherwise: go to COLLECT, seen=nxt, window counter=0.

COLLECT:
- nxt==ALL: go to FIRED, seen=ALL, o=1, fire_count++.
- else if win_limit!=0 and counter==win_limit-1: timeout=1, go to IDLE, seen=0.
- else: seen=nxt, counter++.
- Counter wraps modulo 2^WIN_W when win_limit=0.
- Completion on the same edge as expiry counts as completion; no timeout.

FIRED:
- ev is ignored; seen holds ALL.
- PULSE_MODE=1: o is high only in the first cycle after entry.
- PULSE_MODE=0: o stays high until r is taken.
- Stays in FIRED until r.

Timing and counters:
- Latency: the event edge that completes ALL is followed by o=1 in the next cycle (one-cycle registered latency).
- fire_count saturates at 2^CNT_W-1; further fires leave it unchanged.
- win_limit is sampled every cycle; a change mid-collection takes effect immediately.
- N_IN=1 degenerates to: first ev fires, wait for r.

Decomposition:
- Package abro_pkg holds:
  - the 2-bit state typedef/localparams (IDLE, COLLECT, FIRED);
  - the illegal-code constant;
  - the legal N_IN range check constants.
- One natural sub-module: abro_sat_counter (parametrised width, inc and clear inputs, saturating), used for fire_count.
- Window counter and FSM stay inline.

Test Plan:
1. N_IN=3, PULSE_MODE=1, win_limit=0. Events arrive ev=001, then 100, then 010 on successive edges -> state 00→01→01→10. seen=001,101,111. o=1 for exactly one cycle after the third edge. fire_count=1.
2. N_IN=2, PULSE_MODE=0. ev=11 from IDLE in one cycle -> state=10 and o=1 next cycle. o held for 5 cycles with ev toggling. r=1 -> o=0 and state=00 next cycle. fire_count unchanged at 1.
3. N_IN=2, win_limit=3. ev=01 then idle -> timeout=1 pulse on the 3rd edge after entry to COLLECT; state=00, seen=00, o never asserted.
4. Same setup as 3, but ev=10 on exactly the 3rd edge -> o=1, timeout=0, state=10 (completion wins).
5. r=1 with ev=11 in the same cycle from IDLE -> state stays 00, o=0. Async reset asserted mid-COLLECT -> all outputs 0 immediately, without a clock.
6. CNT_W=2. Four complete fire/restart cycles -> fire_count 1,2,3,3 (saturated).
